register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 The block SHALL have parameter SP_INIT, default 32'h0000_0FFC, giving the reset value of register x2 (stack pointer).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port RR1, input, 5 bits: read address for operand port 1.
REQ-005 The block SHALL have port RR2, input, 5 bits: read address for operand port 2.
REQ-006 The block SHALL have port DATA1, output, 32 bits: operand A to the ALU.
REQ-007 The block SHALL have port DATA2, output, 32 bits: operand B to the ALU.
REQ-008 The block SHALL have port REG_WRITE, input, 1 bit: write-back enable.
REQ-009 The block SHALL have port WR, input, 5 bits: write-back address.
REQ-010 The block SHALL have port WRITE_DATA, input, 32 bits: write-back value (ALU RESULT or load data).
REQ-011 The block SHALL have port ISSUE, input, 1 bit: an instruction with a delayed result is being issued this cycle.
REQ-012 The block SHALL have port ISSUE_RD, input, 5 bits: destination register of the issued instruction.
REQ-013 The block SHALL have port STALL, output, 1 bit: a source register is awaiting write-back.
REQ-014 The block SHALL have port PENDING_CNT, output, 6 bits: registered count of pending registers (0..31).

Function
REQ-015 The block SHALL store 32 registers of 32 bits each; x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-016 Reads SHALL be combinational: DATA1 = reg[RR1] and DATA2 = reg[RR2], with 0 returned for address 0.
REQ-017 On a rising CLK edge with REG_WRITE=1 and WR!=0, reg[WR] SHALL take WRITE_DATA; the new value SHALL be visible on DATA1/DATA2 immediately after the edge.
REQ-018 The block SHALL keep a 32-bit pending vector; bit 0 SHALL always be 0.
REQ-019 On a rising edge with ISSUE=1 and ISSUE_RD!=0, pending[ISSUE_RD] SHALL be set to 1.
REQ-020 On a rising edge with REG_WRITE=1 and WR!=0, pending[WR] SHALL be cleared to 0.
REQ-021 When a set and a clear target the same index on the same edge, the set SHALL win.
REQ-022 STALL SHALL be combinational and equal pending[RR1] OR pending[RR2], subject to REQ-029.
REQ-023 PENDING_CNT SHALL equal the population count of the pending vector after each edge; it SHALL never exceed 31 and SHALL not wrap.
REQ-024 The block SHALL write registers and update pending bits regardless of STALL; holding the pipeline is the caller's job.

Reset
REQ-025 While RESET=1, all registers SHALL be 0 except x2, which SHALL be SP_INIT; the pending vector SHALL be 0; PENDING_CNT SHALL be 0; STALL SHALL be 0.
REQ-026 Reset assertion SHALL take effect without a clock edge, and SHALL discard any write or issue occurring in the same cycle.
REQ-027 On the first rising edge after RESET falls, the block SHALL perform normal writes and issues.

Configuration
REQ-028 Macro REGISTER_BANK_BYPASS_EN SHALL select same-cycle write-through forwarding.
REQ-029 With REGISTER_BANK_BYPASS_EN defined: if REG_WRITE=1, WR!=0 and WR==RR1 (or RR2), DATA1 (or DATA2) SHALL show WRITE_DATA in the same cycle, and that port's pending bit SHALL NOT contribute to STALL in that cycle.
REQ-030 Without REGISTER_BANK_BYPASS_EN: DATA1/DATA2 SHALL show the old value until the edge, and STALL SHALL stay asserted through the write cycle, deasserting the cycle after.

Verification
REQ-031 Scenario 1: assert RESET with RR1=2, RR2=5 -> DATA1=SP_INIT and DATA2=0 with no clock edge; STALL=0; PENDING_CNT=0.
REQ-032 Scenario 2: write WR=0, WRITE_DATA=32'hDEADBEEF, then read RR1=0 -> DATA1=0; write WR=7, WRITE_DATA=32'h12345678 -> DATA2=32'h12345678 with RR2=7 after the edge.
REQ-033 Scenario 3: ISSUE=1, ISSUE_RD=9 for one edge, then RR1=9 -> STALL=1 and PENDING_CNT=1; REG_WRITE with WR=9 and WRITE_DATA=5 -> STALL=1 in the write cycle without the macro, 0 with it (DATA1=5 same cycle); after the edge STALL=0 and PENDING_CNT=0.
REQ-034 Scenario 4: ISSUE_RD=4 and WR=4 on the same edge -> pending[4] stays 1, reg[4] is updated, and PENDING_CNT is unchanged.
REQ-035 Scenario 5: issue x1..x31 over 31 edges -> PENDING_CNT=31; issuing x31 again -> 31 (no wrap); assert RESET mid-sequence -> PENDING_CNT=0 and STALL=0 immediately.

Source files
------------

// File: rtl/register_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : register_bank
// Description : 32x32 register file with two combinational read ports, one
//               write-back port and a pending-result scoreboard that raises
//               STALL. Define REGISTER_BANK_BYPASS_EN for same-cycle
//               write-through forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank #(
  parameter logic [31:0] SP_INIT = 32'h0000_0FFC
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  RR1,
  input  logic [4:0]  RR2,
  output logic [31:0] DATA1,
  output logic [31:0] DATA2,
  input  logic        REG_WRITE,
  input  logic [4:0]  WR,
  input  logic [31:0] WRITE_DATA,
  input  logic        ISSUE,
  input  logic [4:0]  ISSUE_RD,
  output logic        STALL,
  output logic [5:0]  PENDING_CNT
);

  localparam logic [4:0] C_SP_IDX = 5'd2;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic [5:0]  pending_cnt_q;
  logic [5:0]  pending_cnt_d;

  logic wr_en;
  logic issue_en;
  logic byp1;
  logic byp2;

  assign wr_en    = REG_WRITE && (WR != 5'd0);
  assign issue_en = ISSUE && (ISSUE_RD != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WR] = WRITE_DATA;
    end
  end

  // Clear before set so an issue wins over a write-back to the same index.
  always_comb begin
    pending_d = pending_q;
    if (wr_en) begin
      pending_d[WR] = 1'b0;
    end
    if (issue_en) begin
      pending_d[ISSUE_RD] = 1'b1;
    end
    pending_d[0] = 1'b0;
    pending_cnt_d = 6'd0;
    for (int i = 1; i < 32; i++) begin
      pending_cnt_d = pending_cnt_d + 6'(pending_d[i]);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (5'(i) == C_SP_IDX) ? SP_INIT : 32'd0;
      end
      pending_q     <= 32'd0;
      pending_cnt_q <= 6'd0;
    end else begin
      regs_q        <= regs_d;
      pending_q     <= pending_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

`ifdef REGISTER_BANK_BYPASS_EN
  // Forwarding is suppressed while RESET holds the bank at its reset image.
  assign byp1 = wr_en && !RESET && (WR == RR1);
  assign byp2 = wr_en && !RESET && (WR == RR2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    DATA1 = 32'd0;
    DATA2 = 32'd0;
    if (RR1 != 5'd0) begin
      DATA1 = byp1 ? WRITE_DATA : regs_q[RR1];
    end
    if (RR2 != 5'd0) begin
      DATA2 = byp2 ? WRITE_DATA : regs_q[RR2];
    end
  end

  assign STALL       = (pending_q[RR1] && !byp1) || (pending_q[RR2] && !byp2);
  assign PENDING_CNT = pending_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_register_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_register_bank
// Description : Self-checking bench for register_bank against an array-based
//               model of the register file and pending set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_bank;

  localparam logic [31:0] C_SP = 32'h0000_0FFC;
`ifdef REGISTER_BANK_BYPASS_EN
  localparam bit C_BYP = 1'b1;
`else
  localparam bit C_BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  RR1, RR2, WR, ISSUE_RD;
  logic        REG_WRITE, ISSUE;
  logic [31:0] WRITE_DATA;
  logic [31:0] DATA1, DATA2;
  logic        STALL;
  logic [5:0]  PENDING_CNT;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  register_bank #(.SP_INIT(C_SP)) dut (
    .CLK(CLK), .RESET(RESET), .RR1(RR1), .RR2(RR2), .DATA1(DATA1), .DATA2(DATA2),
    .REG_WRITE(REG_WRITE), .WR(WR), .WRITE_DATA(WRITE_DATA), .ISSUE(ISSUE),
    .ISSUE_RD(ISSUE_RD), .STALL(STALL), .PENDING_CNT(PENDING_CNT)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = (i == 2) ? C_SP : 32'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (REG_WRITE && WR != 0) begin
      m_regs[WR] = WRITE_DATA;
      m_pend[WR] = 1'b0;
    end
    if (ISSUE && ISSUE_RD != 0) m_pend[ISSUE_RD] = 1'b1;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (C_BYP && !RESET && REG_WRITE && WR == a) return WRITE_DATA;
    return m_regs[a];
  endfunction

  function automatic logic exp_stall();
    logic f1, f2;
    f1 = C_BYP && !RESET && REG_WRITE && WR != 0 && WR == RR1;
    f2 = C_BYP && !RESET && REG_WRITE && WR != 0 && WR == RR2;
    return (m_pend[RR1] && !f1) || (m_pend[RR2] && !f2);
  endfunction

  function automatic logic [5:0] exp_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return 6'(c);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    REG_WRITE = 1'b0; WR = 5'd0; WRITE_DATA = 32'd0;
    ISSUE = 1'b0; ISSUE_RD = 5'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!RESET) model_edge();
    #1;
  endtask

  task automatic reset_pulse();
    idle();
    RESET = 1'b1;
    model_reset();
    #2;
    RESET = 1'b0;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] wd;
    idle();
    RR1 = 5'd2; RR2 = 5'd5;
    RESET = 1'b0;
    #2 RESET = 1'b1;
    model_reset();
    #1;
    checks++; if (DATA1 !== C_SP) begin failures++; $display("FAIL reset_data1 got=%h exp=%h", DATA1, C_SP); end
    checks++; if (DATA2 !== 32'd0) begin failures++; $display("FAIL reset_data2 got=%h exp=0", DATA2); end
    tick(); tick();
    RESET = 1'b0;
    #1;
    // Build some state, then reset asynchronously mid-cycle.
    wd = $urandom;
    REG_WRITE = 1'b1; WR = 5'd5; WRITE_DATA = wd;
    ISSUE = 1'b1; ISSUE_RD = 5'd6;
    tick();
    idle(); ISSUE = 1'b1; ISSUE_RD = 5'd5;
    tick();
    idle(); REG_WRITE = 1'b1; WR = 5'd5; WRITE_DATA = ~wd; ISSUE = 1'b1; ISSUE_RD = 5'd7;
    #2 RESET = 1'b1;
    model_reset();
    #1;
    checks++; if (DATA1 !== C_SP) begin failures++; $display("FAIL async_reset_data1 got=%h exp=%h", DATA1, C_SP); end
    checks++; if (DATA2 !== 32'd0) begin failures++; $display("FAIL async_reset_data2 got=%h exp=0", DATA2); end
    checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL async_reset_stall got=%b exp=0", STALL); end
    checks++; if (PENDING_CNT !== 6'd0) begin failures++; $display("FAIL async_reset_cnt got=%0d exp=0", PENDING_CNT); end
    tick();
    checks++; if (DATA2 !== 32'd0) begin failures++; $display("FAIL reset_discards_write got=%h exp=0", DATA2); end
    #2 RESET = 1'b0;
    tick();
    checks++; if (DATA2 !== ~wd) begin failures++; $display("FAIL first_edge_write got=%h exp=%h", DATA2, ~wd); end
    checks++; if (PENDING_CNT !== exp_cnt()) begin failures++; $display("FAIL first_edge_issue got=%0d exp=%0d", PENDING_CNT, exp_cnt()); end
  endtask

  task automatic test_x0_and_write();
    reset_pulse();
    RR1 = 5'd0; RR2 = 5'd7;
    REG_WRITE = 1'b1; WR = 5'd0; WRITE_DATA = 32'hDEADBEEF;
    #1;
    checks++; if (DATA1 !== 32'd0) begin failures++; $display("FAIL x0_no_forward got=%h exp=0", DATA1); end
    tick();
    idle();
    #1;
    checks++; if (DATA1 !== 32'd0) begin failures++; $display("FAIL x0_read got=%h exp=0", DATA1); end
    REG_WRITE = 1'b1; WR = 5'd7; WRITE_DATA = 32'h12345678;
    tick();
    idle();
    #1;
    checks++; if (DATA2 !== 32'h12345678) begin failures++; $display("FAIL x7_write got=%h exp=12345678", DATA2); end
  endtask

  task automatic test_issue_stall();
    reset_pulse();
    ISSUE = 1'b1; ISSUE_RD = 5'd9;
    tick();
    idle(); RR1 = 5'd9; RR2 = 5'd0;
    #1;
    checks++; if (STALL !== 1'b1) begin failures++; $display("FAIL issue_stall got=%b exp=1", STALL); end
    checks++; if (PENDING_CNT !== 6'd1) begin failures++; $display("FAIL issue_cnt got=%0d exp=1", PENDING_CNT); end
    REG_WRITE = 1'b1; WR = 5'd9; WRITE_DATA = 32'd5;
    #1;
    checks++; if (STALL !== !C_BYP) begin failures++; $display("FAIL wb_cycle_stall got=%b exp=%b", STALL, !C_BYP); end
    checks++; if (DATA1 !== (C_BYP ? 32'd5 : 32'd0)) begin failures++; $display("FAIL wb_cycle_data1 got=%h exp=%h", DATA1, C_BYP ? 32'd5 : 32'd0); end
    tick();
    idle();
    #1;
    checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL wb_after_stall got=%b exp=0", STALL); end
    checks++; if (PENDING_CNT !== 6'd0) begin failures++; $display("FAIL wb_after_cnt got=%0d exp=0", PENDING_CNT); end
    checks++; if (DATA1 !== 32'd5) begin failures++; $display("FAIL wb_after_data1 got=%h exp=5", DATA1); end
  endtask

  task automatic test_same_edge();
    logic [31:0] wd;
    reset_pulse();
    wd = $urandom;
    ISSUE = 1'b1; ISSUE_RD = 5'd4;
    tick();
    ISSUE = 1'b1; ISSUE_RD = 5'd4;
    REG_WRITE = 1'b1; WR = 5'd4; WRITE_DATA = wd;
    tick();
    idle(); RR1 = 5'd4; RR2 = 5'd0;
    #1;
    checks++; if (PENDING_CNT !== 6'd1) begin failures++; $display("FAIL same_edge_cnt got=%0d exp=1", PENDING_CNT); end
    checks++; if (STALL !== 1'b1) begin failures++; $display("FAIL same_edge_stall got=%b exp=1", STALL); end
    checks++; if (DATA1 !== wd) begin failures++; $display("FAIL same_edge_data got=%h exp=%h", DATA1, wd); end
  endtask

  task automatic test_saturation();
    reset_pulse();
    for (int i = 1; i < 32; i++) begin
      ISSUE = 1'b1; ISSUE_RD = 5'(i);
      tick();
    end
    checks++; if (PENDING_CNT !== 6'd31) begin failures++; $display("FAIL sat_cnt got=%0d exp=31", PENDING_CNT); end
    ISSUE_RD = 5'd31;
    tick();
    idle(); RR1 = 5'd31; RR2 = 5'd1;
    #1;
    checks++; if (PENDING_CNT !== 6'd31) begin failures++; $display("FAIL sat_no_wrap got=%0d exp=31", PENDING_CNT); end
    checks++; if (STALL !== 1'b1) begin failures++; $display("FAIL sat_stall got=%b exp=1", STALL); end
    reset_pulse();
    for (int i = 1; i <= 10; i++) begin
      ISSUE = 1'b1; ISSUE_RD = 5'(i);
      tick();
    end
    RR1 = 5'd3; RR2 = 5'd8;
    #1 RESET = 1'b1;
    model_reset();
    #1;
    checks++; if (PENDING_CNT !== 6'd0) begin failures++; $display("FAIL mid_reset_cnt got=%0d exp=0", PENDING_CNT); end
    checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL mid_reset_stall got=%b exp=0", STALL); end
    idle();
    #1 RESET = 1'b0;
    tick();
  endtask

  task automatic test_random();
    reset_pulse();
    for (int n = 0; n < 400; n++) begin
      REG_WRITE  = ($urandom_range(0, 99) < 45);
      WR         = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      WRITE_DATA = $urandom;
      ISSUE      = ($urandom_range(0, 99) < 50);
      ISSUE_RD   = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      RR1        = 5'($urandom_range(0, 7));
      RR2        = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      #1;
      checks++; if (DATA1 !== exp_data(RR1)) begin failures++; $display("FAIL rand_data1 n=%0d rr1=%0d got=%h exp=%h", n, RR1, DATA1, exp_data(RR1)); end
      checks++; if (DATA2 !== exp_data(RR2)) begin failures++; $display("FAIL rand_data2 n=%0d rr2=%0d got=%h exp=%h", n, RR2, DATA2, exp_data(RR2)); end
      checks++; if (STALL !== exp_stall()) begin failures++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, STALL, exp_stall()); end
      tick();
      checks++; if (PENDING_CNT !== exp_cnt()) begin failures++; $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, PENDING_CNT, exp_cnt()); end
    end
    idle();
  endtask

  initial begin
    idle();
    RR1 = 5'd0; RR2 = 5'd0; RESET = 1'b0;
    model_reset();
    test_reset();
    test_x0_and_write();
    test_issue_stall();
    test_same_edge();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
